// File: rtl/sub_serial.sv
// Bit-serial subtractor: d = a - b - bi, one bit per clock, LSB first, with
// a single borrow flip-flop and a start/busy/done handshake.
//
// Ports:
//   clk    - system clock, all state updates on the rising edge
//   rst    - synchronous active-high reset
//   start  - request, sampled only while idle
//   a, b   - minuend / subtrahend, latched when start is accepted
//   bi     - borrow-in, latched when start is accepted
//   d, bo  - difference / borrow-out, updated on entry to the done cycle and
//            held until the next done
//   busy   - high while bits are being processed
//   done   - one-cycle pulse, result valid
//   ovf    - two's-complement overflow, present only with SUB_SERIAL_OVF_EN
//
// Optional feature macro: SUB_SERIAL_OVF_EN (adds the ovf output).
module sub_serial #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             busy,
    output logic             done
`ifdef SUB_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] r_sr_q, r_sr_d;
    logic             br_q, br_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bo_q, bo_d;
`ifdef SUB_SERIAL_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic x, y, diff_bit, br_new;

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        r_sr_d  = r_sr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        bo_d    = bo_q;
`ifdef SUB_SERIAL_OVF_EN
        ovf_d   = ovf_q;
`endif

        x        = a_sr_q[0];
        y        = b_sr_q[0];
        diff_bit = x ^ y ^ br_q;
        br_new   = (~x & y) | (~(x ^ y) & br_q);

        case (state_q)
            StIdle: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    br_d    = bi;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                r_sr_d = {diff_bit, r_sr_q[WIDTH-1:1]};
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                br_d   = br_new;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    // On the last bit x/y are the operand MSBs and diff_bit is the
                    // result MSB, so the outputs can be loaded straight from here.
                    d_d     = {diff_bit, r_sr_q[WIDTH-1:1]};
                    bo_d    = br_new;
`ifdef SUB_SERIAL_OVF_EN
                    ovf_d   = (x ^ y) & (x ^ diff_bit);
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            r_sr_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            bo_q    <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            r_sr_q  <= r_sr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            bo_q    <= bo_d;
`ifdef SUB_SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign d    = d_q;
    assign bo   = bo_q;
    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
`ifdef SUB_SERIAL_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial (WIDTH=4): directed boundary cases,
// start-ignore, mid-run reset, back-to-back operation and random operands.
module tb_sub_serial;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         bi;
    logic [W-1:0] d;
    logic         bo, busy, done;
`ifdef SUB_SERIAL_OVF_EN
    logic         ovf;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    sub_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bi    (bi),
        .d     (d),
        .bo    (bo),
        .busy  (busy),
        .done  (done)
`ifdef SUB_SERIAL_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed views.
    function automatic logic [W-1:0] ref_d(input int ua, input int ub, input int ubi);
        int diff = ua - ub - ubi;
        if (diff < 0) diff += (1 << W);
        return W'(diff);
    endfunction

    function automatic logic ref_bo(input int ua, input int ub, input int ubi);
        return (ua < ub + ubi);
    endfunction

    function automatic logic ref_ovf(input int ua, input int ub, input int ubi);
        int sa   = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
        int sb   = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
        int sres = sa - sb - ubi;
        return (sres < -(1 << (W - 1))) || (sres > (1 << (W - 1)) - 1);
    endfunction

    // Entered and left at a falling edge with the DUT idle.
    task automatic do_op(input int ua, input int ub, input int ubi, input string tag);
        logic [W-1:0] ed  = ref_d(ua, ub, ubi);
        logic         ebo = ref_bo(ua, ub, ubi);
        start = 1'b1;
        a     = W'(ua);
        b     = W'(ub);
        bi    = ubi[0];
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        bi    = 1'($urandom);
        for (int k = 1; k <= W; k++) begin
            chk({tag, " busy/done in run"}, 32'({busy, done}), 32'b10);
            @(negedge clk);
        end
        chk({tag, " busy/done at done"}, 32'({busy, done}), 32'b01);
        chk({tag, " d"}, 32'(d), 32'(ed));
        chk({tag, " bo"}, 32'(bo), 32'(ebo));
`ifdef SUB_SERIAL_OVF_EN
        chk({tag, " ovf"}, 32'(ovf), 32'(ref_ovf(ua, ub, ubi)));
`endif
        @(negedge clk);
        chk({tag, " done cleared"}, 32'(done), 32'd0);
        chk({tag, " d held"}, 32'({bo, d}), 32'({ebo, ed}));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        int last_cyc;
        int ea[3], eb[3];

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bi    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset d", 32'(d), 32'd0);
        chk("reset bo/busy/done", 32'({bo, busy, done}), 32'd0);
`ifdef SUB_SERIAL_OVF_EN
        chk("reset ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;

        do_op(7, 3, 0, "7-3");
        do_op(3, 7, 0, "3-7");
        do_op(0, 0, 1, "0-0-1");
        do_op(15, 15, 0, "F-F");
        do_op(15, 0, 0, "F-0");
        do_op(9, 9, 0, "a=b");
        do_op(8, 1, 0, "8-1");
        do_op(7, 15, 0, "7-F");
        do_op(5, 3, 0, "5-3");

        // start re-pulsed mid-run must be ignored.
        start = 1'b1; a = 4'd7; b = 4'd3; bi = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 4'd1; b = 4'd1;
        @(negedge clk);
        start = 1'b0; a = 4'd12; b = 4'd5; bi = 1'b1;
        ndone = 0;
        for (int c = 3; c <= int'(W) + 5; c++) begin
            if (done) begin
                ndone++;
                chk("repulse done cycle", 32'(c), 32'(W + 1));
                chk("repulse d", 32'({bo, d}), 32'h4);
            end
            @(negedge clk);
        end
        chk("repulse done count", 32'(ndone), 32'd1);

        // Reset during run discards the operation.
        start = 1'b1; a = 4'd9; b = 4'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy/done", 32'({busy, done}), 32'd0);
        chk("midrst d/bo", 32'({bo, d}), 32'd0);
        ndone = 0;
        for (int c = 0; c < int'(W) + 2; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("midrst no done", 32'(ndone), 32'd0);
        do_op(7, 3, 0, "post-rst");

        // start held high: three back-to-back operations.
        ea = '{9, 2, 5};
        eb = '{2, 9, 5};
        start = 1'b1; a = W'(ea[0]); b = W'(eb[0]); bi = 1'b0;
        ndone = 0;
        last_cyc = 0;
        for (int cyc = 1; cyc <= 3 * (int'(W) + 2) + 3; cyc++) begin
            @(negedge clk);
            if (done) begin
                if (ndone < 3) begin
                    chk("b2b d", 32'(d), 32'(ref_d(ea[ndone], eb[ndone], 0)));
                    chk("b2b bo", 32'(bo), 32'(ref_bo(ea[ndone], eb[ndone], 0)));
                end
                if (ndone == 0) chk("b2b first done", 32'(cyc), 32'(W + 1));
                else chk("b2b spacing", 32'(cyc - last_cyc), 32'(W + 2));
                ndone++;
                last_cyc = cyc;
                if (ndone < 3) begin
                    a = W'(ea[ndone]);
                    b = W'(eb[ndone]);
                end else begin
                    start = 1'b0;
                end
            end
        end
        chk("b2b done count", 32'(ndone), 32'd3);
        while (busy || done) @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            do_op(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
                  int'($urandom_range(0, 1)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
